fir_filter_mc: RTL and testbench

FIR_FILTER_MC -- requirements
Module: fir_filter_mc

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_filter_mc_if.sv | 22 ++
 rtl/fir_mac.sv | 39 +++
 rtl/fir_filter_mc.sv | 146 ++++++++++++++
 tb/tb_fir_filter_mc.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg -- shared types and sizing helpers for the multi-channel FIR filter.
//   fir_state_e : controller states (IDLE -> MAC -> OUT -> IDLE)
//   acc_width() : full-precision accumulator width for a given data/coef/tap count
//   chan_width(): channel-index width, never less than one bit
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Sum of NUM_TAPS full-width products cannot overflow this width.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  function automatic int chan_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/fir_filter_mc_if.sv
// fir_filter_mc_if -- sample-in / result-out stream bundle for fir_filter_mc.
//   s_valid/s_ready/s_data/s_chan : input sample handshake + channel index
//   m_valid/m_ready/m_data/m_chan : filtered result handshake + channel tag
// Modports: slave = the filter, master = the surrounding source/sink.
interface fir_filter_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_W       = 1
);
  logic                         s_valid;
  logic                         s_ready;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic [CH_W-1:0]              s_chan;
  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH-1:0] m_data;
  logic [CH_W-1:0]              m_chan;

  modport slave  (input  s_valid, s_data, s_chan, m_ready,
                  output s_ready, m_valid, m_data, m_chan);
  modport master (output s_valid, s_data, s_chan, m_ready,
                  input  s_ready, m_valid, m_data, m_chan);
endinterface

// File: rtl/fir_mac.sv
// fir_mac -- two-stage signed multiply-accumulate.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the accumulator and flush the product stage
//   en         : a*b is valid this cycle; it reaches acc two edges later
//   a, b       : signed operands
//   acc        : running full-precision sum
module fir_mac #(
  parameter int AW    = 16,
  parameter int BW    = 16,
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);
  localparam int STAGES = 1;

  logic [STAGES:1]          vld_q;
  logic [STAGES:0]          vld_pipe;
  logic signed [AW+BW-1:0]  prod_q;

  assign vld_pipe = {vld_q, en};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      vld_q  <= '0;
      prod_q <= '0;
      acc    <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (en) prod_q <= (AW+BW)'(a) * (AW+BW)'(b);
      if (vld_pipe[STAGES]) acc <= acc + ACC_W'(prod_q);
    end
  end
endmodule

// File: rtl/fir_filter_mc.sv
// fir_filter_mc -- time-multiplexed FIR, one MAC per cycle, shared coefficients.
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : sample in (s_*) and result out (m_*) handshakes
//   coef_wr_en/addr/data: coefficient write, honoured only while idle
//   coef_drop           : sticky flag, a coefficient write was discarded
// Build option: define FIR_OUT_SAT_EN to clamp the output instead of wrapping.
// Result appears NUM_TAPS+2 edges after the accepting edge (one extra edge for
// the registered product stage inside fir_mac).
module fir_filter_mc
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_TAPS   = 16,
  parameter int NUM_CH     = 2,
  parameter int OUT_SHIFT  = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  fir_filter_mc_if.slave               bus,
  input  logic                         coef_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0]  coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
  output logic                         coef_drop
);
  localparam int CH_W  = chan_width(NUM_CH);
  localparam int TAP_W = $clog2(NUM_TAPS);
  localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
  localparam int RND_W = ACC_W + 1;
  localparam int K_W   = $clog2(NUM_TAPS + 2) + 1;
  // Unity gain at reset, clipped when 2^OUT_SHIFT does not fit the coef word.
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = (OUT_SHIFT >= COEF_WIDTH-1) ?
    COEF_WIDTH'((64'sd1 <<< (COEF_WIDTH-1)) - 64'sd1) : COEF_WIDTH'(64'sd1 <<< OUT_SHIFT);
  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(64'sd1 <<< (OUT_SHIFT-1));

  fir_state_e                   state;
  logic signed [DATA_WIDTH-1:0] dl [NUM_CH][NUM_TAPS];
  logic [TAP_W-1:0]             wptr [NUM_CH];
  logic signed [COEF_WIDTH-1:0] coef [NUM_TAPS];
  logic [CH_W-1:0]              cur_ch;
  logic [TAP_W-1:0]             rd;
  logic [K_W-1:0]               k;
  logic                         m_valid_q;
  logic signed [DATA_WIDTH-1:0] m_data_q;
  logic [CH_W-1:0]              m_chan_q;
  logic signed [ACC_W-1:0]      acc;
  logic signed [RND_W-1:0]      rnd, shifted;
  logic signed [DATA_WIDTH-1:0] result;
  logic                         accept, chan_ok, coef_ok;

  assign bus.s_ready = (state == ST_IDLE);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_chan  = m_chan_q;

  assign accept  = bus.s_valid && (state == ST_IDLE);
  assign chan_ok = int'(bus.s_chan) < NUM_CH;
  assign coef_ok = (state == ST_IDLE) && (int'(coef_wr_addr) < NUM_TAPS);

  function automatic logic [TAP_W-1:0] ptr_inc(input logic [TAP_W-1:0] p);
    return (p == TAP_W'(NUM_TAPS-1)) ? '0 : p + TAP_W'(1);
  endfunction

  function automatic logic [TAP_W-1:0] ptr_dec(input logic [TAP_W-1:0] p);
    return (p == '0) ? TAP_W'(NUM_TAPS-1) : p - TAP_W'(1);
  endfunction

  // rd walks backwards from the newest sample, so tap k reads x[n-k].
  fir_mac #(.AW(DATA_WIDTH), .BW(COEF_WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (state == ST_IDLE),
    .en   ((state == ST_MAC) && (int'(k) < NUM_TAPS)),
    .a    (dl[cur_ch][rd]),
    .b    (coef[k[TAP_W-1:0]]),
    .acc  (acc)
  );

  // Round half up, then reduce to the output width.
  assign rnd     = RND_W'(acc) + RND_HALF;
  assign shifted = rnd >>> OUT_SHIFT;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [RND_W-1:0] OMAX = RND_W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [RND_W-1:0] OMIN = -OMAX - RND_W'(1);
  always_comb begin
    result = shifted[DATA_WIDTH-1:0];
    if (shifted > OMAX)      result = OMAX[DATA_WIDTH-1:0];
    else if (shifted < OMIN) result = OMIN[DATA_WIDTH-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[RND_W-1:DATA_WIDTH];
  assign result    = shifted[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < NUM_TAPS; t++) dl[c][t] <= '0;
      end
      for (int t = 0; t < NUM_TAPS; t++) coef[t] <= (t == 0) ? COEF_ONE : '0;
      cur_ch    <= '0;
      rd        <= '0;
      k         <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
      coef_drop <= 1'b0;
    end else begin
      // Coefficient write lands on the accepting edge, ahead of the first MAC.
      if (coef_wr_en) begin
        if (coef_ok) coef[coef_wr_addr] <= coef_wr_data;
        else         coef_drop <= 1'b1;
      end
      case (state)
        ST_IDLE: if (accept && chan_ok) begin
          dl[bus.s_chan][wptr[bus.s_chan]] <= bus.s_data;
          wptr[bus.s_chan] <= ptr_inc(wptr[bus.s_chan]);
          rd     <= wptr[bus.s_chan];
          cur_ch <= bus.s_chan;
          k      <= '0;
          state  <= ST_MAC;
        end
        ST_MAC: begin
          rd <= ptr_dec(rd);
          k  <= k + K_W'(1);
          // Last product has drained into acc by the time k hits NUM_TAPS+1.
          if (k == K_W'(NUM_TAPS + 1)) begin
            m_valid_q <= 1'b1;
            m_data_q  <= result;
            m_chan_q  <= cur_ch;
            state     <= ST_OUT;
          end
        end
        ST_OUT: if (bus.m_ready) begin
          m_valid_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_filter_mc.sv
// tb_fir_filter_mc -- directed self-checking bench for fir_filter_mc.
// NUM_CH=3 gives a 2-bit s_chan so channel index 3 is out of range.
module tb_fir_filter_mc;
  localparam int DW = 16, CW = 16, NT = 16, NCH = 3, OS = 15, CHW = 2;
  localparam int LAT = NT + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        coef_wr_en = 1'b0;
  logic [3:0]  coef_wr_addr = '0;
  logic [15:0] coef_wr_data = '0;
  logic        coef_drop;
  int          checks = 0;
  int          errors = 0;

  fir_filter_mc_if #(.DATA_WIDTH(DW), .CH_W(CHW)) bus ();

  fir_filter_mc #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT), .NUM_CH(NCH), .OUT_SHIFT(OS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .coef_wr_en  (coef_wr_en),
    .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data),
    .coef_drop   (coef_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_chan = '0; bus.m_ready = 1'b0;
    coef_wr_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [15:0] d);
    coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = d;
    @(posedge clk); #1 coef_wr_en = 1'b0;
  endtask

  // Presents one sample; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] ch, input logic [15:0] d);
    int n = 0;
    while (!bus.s_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: s_ready=%b required 1", bus.s_ready);
    end
    bus.s_valid = 1'b1; bus.s_chan = ch; bus.s_data = d;
    @(posedge clk); #1 bus.s_valid = 1'b0;
  endtask

  // Waits for a result with m_ready high; lat = edges since accept, -1 on timeout.
  task automatic get(output logic [15:0] d, output logic [1:0] ch, output int lat);
    lat = -1; bus.m_ready = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.m_valid) begin lat = i; break; end
    end
    d = bus.m_data; ch = bus.m_chan;
    @(posedge clk); #1 bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b req 1", bus.s_ready); end
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b req 0", bus.m_valid); end
    if (bus.m_data !== 16'h0) begin errors++; $display("FAIL rst_m_data: got %h req 0000", bus.m_data); end
    if (bus.m_chan !== 2'd0)  begin errors++; $display("FAIL rst_m_chan: got %0d req 0", bus.m_chan); end
    if (coef_drop !== 1'b0)   begin errors++; $display("FAIL rst_coef_drop: got %b req 0", coef_drop); end
  endtask

  task automatic test_identity();
    logic [15:0] d; logic [1:0] ch; int lat;
    logic [15:0] din [3] = '{16'd1000, 16'hFC18, 16'd7};
    logic [1:0]  cin [3] = '{2'd0, 2'd0, 2'd2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(cin[i], din[i]);
      get(d, ch, lat);
      checks += 3;
      if (lat != LAT)     begin errors++; $display("FAIL ident_lat[%0d]: got %0d req %0d", i, lat, LAT); end
      if (d !== din[i])   begin errors++; $display("FAIL ident_data[%0d]: got %h req %h", i, d, din[i]); end
      if (ch !== cin[i])  begin errors++; $display("FAIL ident_chan[%0d]: got %0d req %0d", i, ch, cin[i]); end
    end
  endtask

  task automatic test_same_cycle_coef();
    logic [15:0] d; logic [1:0] ch; int lat;
    do_reset();
    coef_wr_en = 1'b1; coef_wr_addr = 4'd0; coef_wr_data = 16'h4000;
    send(2'd0, 16'd1000);
    coef_wr_en = 1'b0;
    get(d, ch, lat);
    checks += 2;
    if (d !== 16'd500)    begin errors++; $display("FAIL samecyc_data: got %0d req 500", d); end
    if (coef_drop !== 1'b0) begin errors++; $display("FAIL samecyc_drop: got %b req 0", coef_drop); end
  endtask

  task automatic test_impulse();
    logic [15:0] d; logic [1:0] ch; int lat;
    do_reset();
    for (int t = 0; t < NT; t++) wr_coef(4'(t), 16'h0800);
    for (int i = 0; i < NT; i++) begin
      send(2'd1, (i == 0) ? 16'h4000 : 16'h0000);
      get(d, ch, lat);
      checks += 2;
      if (d !== 16'h0400) begin errors++; $display("FAIL impulse_data[%0d]: got %h req 0400", i, d); end
      if (ch !== 2'd1)    begin errors++; $display("FAIL impulse_chan[%0d]: got %0d req 1", i, ch); end
    end
    send(2'd1, 16'h0000);
    get(d, ch, lat);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL impulse_aged: got %h req 0000", d); end
    send(2'd0, 16'h0000);
    get(d, ch, lat);
    checks += 2;
    if (d !== 16'h0000) begin errors++; $display("FAIL impulse_ch0: got %h req 0000", d); end
    if (ch !== 2'd0)    begin errors++; $display("FAIL impulse_ch0_chan: got %0d req 0", ch); end
  endtask

  task automatic test_sat();
    logic [15:0] d; logic [1:0] ch; int lat;
    logic [15:0] din [4] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
`ifdef FIR_OUT_SAT_EN
    logic [15:0] exp [4] = '{16'h7FFE, 16'h7FFF, 16'hFFFF, 16'h8000};
`else
    logic [15:0] exp [4] = '{16'h7FFE, 16'hFFFC, 16'hFFFF, 16'h0002};
`endif
    do_reset();
    wr_coef(4'd0, 16'h7FFF);
    wr_coef(4'd1, 16'h7FFF);
    for (int i = 0; i < 4; i++) begin
      send(2'd0, din[i]);
      get(d, ch, lat);
      checks++;
      if (d !== exp[i]) begin errors++; $display("FAIL sat_data[%0d]: got %h req %h", i, d, exp[i]); end
    end
  endtask

  task automatic test_coef_drop();
    logic [15:0] d; logic [1:0] ch; int lat;
    do_reset();
    send(2'd0, 16'd1000);
    wr_coef(4'd0, 16'h0000);
    checks++;
    if (coef_drop !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b req 1", coef_drop); end
    get(d, ch, lat);
    checks++;
    if (d !== 16'd1000) begin errors++; $display("FAIL drop_data: got %0d req 1000", d); end
    send(2'd0, 16'd1000);
    get(d, ch, lat);
    checks += 2;
    if (d !== 16'd1000)     begin errors++; $display("FAIL drop_next: got %0d req 1000", d); end
    if (coef_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b req 1", coef_drop); end
  endtask

  task automatic test_backpressure();
    logic [15:0] d; logic [1:0] ch; int lat; int seen; int bad;
    do_reset();
    send(2'd0, 16'd1234);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin @(posedge clk); #1; if (bus.m_valid) seen = 1; end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_valid: got 0 req 1"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 16'd1234 || bus.s_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles req 0 (m_data=%0d)", bad, bus.m_data); end
    bus.m_ready = 1'b1;
    @(posedge clk); #1 bus.m_ready = 1'b0;
    checks += 2;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b req 0", bus.m_valid); end
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b req 1", bus.s_ready); end
    // Out-of-range channel: swallowed, no result, controller stays idle.
    send(2'd3, 16'd500);
    checks++;
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL badch_idle: s_ready=%b req 1", bus.s_ready); end
    bus.m_ready = 1'b1; seen = 0;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (bus.m_valid) seen = 1; end
    bus.m_ready = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL badch_output: m_valid seen=%0d req 0", seen); end
    send(2'd0, 16'd42);
    get(d, ch, lat);
    checks += 2;
    if (d !== 16'd42) begin errors++; $display("FAIL badch_after: got %0d req 42", d); end
    if (lat != LAT)   begin errors++; $display("FAIL badch_lat: got %0d req %0d", lat, LAT); end
  endtask

  task automatic test_reset_mid_mac();
    logic [15:0] d; logic [1:0] ch; int lat; int seen;
    do_reset();
    for (int t = 0; t < NT; t++) wr_coef(4'(t), 16'h0800);
    send(2'd0, 16'h4000);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: s_ready=%b req 1", bus.s_ready); end
    bus.m_ready = 1'b1; seen = 0;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (bus.m_valid) seen = 1; end
    bus.m_ready = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_output: m_valid seen=%0d req 0", seen); end
    for (int t = 0; t < NT; t++) wr_coef(4'(t), 16'h0800);
    send(2'd0, 16'h0000);
    get(d, ch, lat);
    checks += 2;
    if (d !== 16'h0000) begin errors++; $display("FAIL midrst_cleared: got %h req 0000", d); end
    if (lat != LAT)     begin errors++; $display("FAIL midrst_lat: got %0d req %0d", lat, LAT); end
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_chan = '0; bus.m_ready = 1'b0;
    test_reset();
    test_identity();
    test_same_cycle_coef();
    test_impulse();
    test_sat();
    test_coef_drop();
    test_backpressure();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
